pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Drives the CE/flush inputs of the 32-bit pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  It detects load-use hazards, stretches the pipeline over slow instruction/data memory with a
//  ready handshake, squashes the wrong-path fetch on a taken branch, and traps on a memory timeout.
//  It sits beside the datapath in the top-level CPU. Each register holds when its CE is low.
// PARAMETERS
//  REG_ADDR_W  5   width of register-file address fields
//  TIMEOUT     16  max consecutive wait cycles allowed before a bus error (>=2)
//  CNT_W       32  width of the stall performance counter
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           reset, asynchronous assert, active-low
//  id_rs, id_rt  in   REG_ADDR_W  source register numbers of the instruction in ID
//  id_use_rs/rt  in   1 each      ID instruction actually reads rs / rt
//  ex_mem_read   in   1           the instruction in EX is a load
//  ex_rd         in   REG_ADDR_W  destination register of the instruction in EX
//  branch_taken  in   1           branch resolved taken in ID this cycle
//  imem_ready    in   1           instruction memory returns the fetch this cycle
//  mem_req       in   1           the instruction in MEM accesses data memory
//  mem_ready     in   1           data memory completes the access this cycle
//  pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce   out  1 each  register enables
//  ifid_flush    out  1           load NOP into IF/ID on this edge
//  idex_flush    out  1           load bubble into ID/EX on this edge
//  memwb_flush   out  1           load bubble into MEM/WB on this edge
//  bus_err       out  1           sticky timeout flag
//  stall_cnt     out  CNT_W       count of cycles with pc_ce=0, excluding ERR
// BEHAVIOUR
//  - While rst_n=0: all CE and flush outputs are 0, bus_err=0, stall_cnt=0, state=RUN, wait_cnt=0.
//  - State register: RUN, DWAIT, IWAIT, ERR. CE/flush outputs are combinational from state and inputs.
//    There is no added latency.
//  - load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
//  - dstall = mem_req & ~mem_ready; istall = ~imem_ready.
//  - Priority order, first match wins:
//    1. ERR: all CE=0 and all flush=0 until reset.
//    2. dstall: pc/ifid/idex/exmem CE=0, memwb_ce=1, memwb_flush=1. The branch is held, not acted on.
//    3. load_use: pc_ce=ifid_ce=0, idex_ce=1, idex_flush=1, exmem/memwb CE=1. ifid_flush=0.
//    4. istall: pc_ce=0, ifid_ce=1, ifid_flush=1; rest CE=1. If branch_taken, ifid_flush stays 1.
//    5. branch_taken: all CE=1, ifid_flush=1.
//    6. Otherwise: all CE=1, all flush=0.
//  - Transitions:
//    RUN->DWAIT on dstall; RUN->IWAIT on istall & ~dstall.
//    DWAIT->RUN on mem_ready. IWAIT->RUN on imem_ready.
//    IWAIT->DWAIT if dstall arises while in IWAIT; wait_cnt is cleared on that change.
//  - wait_cnt clears on entry to DWAIT or IWAIT and increments each cycle in that state.
//    If the wait is still unresolved at wait_cnt==TIMEOUT-1: go to ERR and set bus_err=1.
//    In that cycle the ready input is sampled first; ready wins over the timeout.
//  - stall_cnt increments on each edge where pc_ce==0 and state!=ERR. It saturates at all-ones.
//  - Reset mid-wait aborts the wait immediately. The first cycle after reset is RUN.
// STRUCTURE
//  - Shared cpu package: state encoding localparams (RUN=2'd0, DWAIT=2'd1, IWAIT=2'd2, ERR=2'd3).
//    The package also holds REG_ADDR_W.
//  - One natural sub-module: hazard_detect, a combinational load_use compare. It is reused later
//    by the forwarding unit. The FSM, counters and output decode stay in this module.
// TESTING
//  1. rst_n=0 with every input active -> all outputs 0.
//     After release with all inputs idle -> every CE=1 and every flush=0.
//  2. Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for one cycle
//     -> pc_ce=ifid_ce=0, idex_flush=1, stall_cnt=1. Repeat with ex_rd=0 -> no stall.
//  3. mem_req=1 with mem_ready low for 3 cycles, then high -> 3 cycles of dstall pattern with
//     memwb_flush=1, then all CE=1. stall_cnt=3. State returns to RUN.
//  4. branch_taken=1 in RUN -> ifid_flush=1 and all CE=1.
//     Same branch during dstall -> ifid_flush=0 until mem_ready arrives.
//  5. imem_ready low for 2 cycles, mem_req/mem_ready low on the 2nd cycle -> IWAIT then DWAIT.
//     Only the dstall pattern is visible on the 2nd cycle.
//  6. mem_ready held low for TIMEOUT cycles -> bus_err=1 and all CE=0 from then on.
//     stall_cnt freezes. rst_n pulse -> clean RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU-control definitions: pipeline control FSM state encoding and the
// register-file address width used by the hazard and forwarding logic.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t RUN   = 2'd0;
  localparam state_t DWAIT = 2'd1;
  localparam state_t IWAIT = 2'd2;
  localparam state_t ERR   = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// is a live source operand of the instruction in ID. Register 0 never hazards.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  // Pure compare, no state
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives the pipeline register enables and flushes,
// stalls on load-use hazards and slow memories, squashes wrong-path fetches
// and traps to a sticky bus error when a memory wait runs too long.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = pipe_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_ce,
  output logic                  ifid_ce,
  output logic                  idex_ce,
  output logic                  exmem_ce,
  output logic                  memwb_ce,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  import pipe_hazard_ctrl_pkg::*;

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic              err_set;
  logic              load_use;
  logic              dstall;
  logic              istall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // Raw stall conditions straight from the memory handshakes
  always_comb begin
    dstall = mem_req && !mem_ready;
    istall = !imem_ready;
  end

  // State, wait counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (err_set) bus_err <= 1'b1;
    end
  end

  // Next state: the ready input is looked at before the timeout, so a
  // completion in the last allowed cycle still counts as success
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    err_set     = 1'b0;
    case (state)
      RUN: begin
        if (dstall) begin
          state_nx    = DWAIT;
          wait_cnt_nx = '0;
        end else if (istall) begin
          state_nx    = IWAIT;
          wait_cnt_nx = '0;
        end
      end
      DWAIT: begin
        if (mem_ready) begin
          state_nx = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERR;
          err_set  = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
        end
      end
      IWAIT: begin
        if (dstall) begin
          state_nx    = DWAIT;
          wait_cnt_nx = '0;
        end else if (imem_ready) begin
          state_nx = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERR;
          err_set  = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_nx = ERR;
    endcase
  end

  // Enable/flush decode, highest priority first; a held branch is only
  // acted on once the data-memory stall clears
  always_comb begin
    pc_ce       = 1'b0;
    ifid_ce     = 1'b0;
    idex_ce     = 1'b0;
    exmem_ce    = 1'b0;
    memwb_ce    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (!rst_n || state == ERR) begin
      pc_ce = 1'b0;
    end else if (dstall) begin
      memwb_ce    = 1'b1;
      memwb_flush = 1'b1;
    end else if (load_use) begin
      idex_ce    = 1'b1;
      idex_flush = 1'b1;
      exmem_ce   = 1'b1;
      memwb_ce   = 1'b1;
    end else if (istall) begin
      ifid_ce    = 1'b1;
      ifid_flush = 1'b1;
      idex_ce    = 1'b1;
      exmem_ce   = 1'b1;
      memwb_ce   = 1'b1;
    end else begin
      pc_ce      = 1'b1;
      ifid_ce    = 1'b1;
      idex_ce    = 1'b1;
      exmem_ce   = 1'b1;
      memwb_ce   = 1'b1;
      ifid_flush = branch_taken;
    end
  end

  // Stall performance counter; cycles spent trapped in ERR are not stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_ce && state != ERR) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
